tap_controller: RTL

TAP_CONTROLLER -- requirements
Module: tap_controller

---
 rtl/tap_controller.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP controller with a 2-bit IR (EXTEST, SAMPLE_PRELOAD, IDCODE, BYPASS); IDCODE register built only under TAP_IDCODE_EN.
// Control outputs decode from registered state, TDO is combinational in Shift-IR/Shift-DR; no backpressure (TMS/TDI paced by Clock).
module tap_controller #(
  parameter logic [31:0] IDCODE_VALUE = 32'h1000_0001
) (
  input  logic Clock,
  input  logic Reset_n,
  input  logic TMS,
  input  logic TDI,
  input  logic BSR_TDO,
  output logic TDO,
  output logic TDO_en,
  output logic BSR_ClockEn,
  output logic Shift_or_Load,
  output logic Update,
  output logic Test_or_Normal
);

  typedef enum logic [3:0] {
    TLR      = 4'h0,
    RTI      = 4'h1,
    SEL_DR   = 4'h2,
    CAP_DR   = 4'h3,
    SHIFT_DR = 4'h4,
    EXIT1_DR = 4'h5,
    PAUSE_DR = 4'h6,
    EXIT2_DR = 4'h7,
    UPD_DR   = 4'h8,
    SEL_IR   = 4'h9,
    CAP_IR   = 4'hA,
    SHIFT_IR = 4'hB,
    EXIT1_IR = 4'hC,
    PAUSE_IR = 4'hD,
    EXIT2_IR = 4'hE,
    UPD_IR   = 4'hF
  } tap_state_t;

  localparam logic [1:0] IR_EXTEST = 2'b00;
`ifdef TAP_IDCODE_EN
  localparam logic [1:0] IR_RESET = 2'b10;
`else
  localparam logic [1:0] IR_RESET = 2'b11;
`endif

  tap_state_t state;
  logic [1:0] ir;
  logic [1:0] ir_sr;
  logic       bypass_reg;
  logic       bsr_sel;
  logic       id_sel;
  logic       id_lsb;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= TLR;
    end else begin
      case (state)
        TLR:      state <= TMS ? TLR      : RTI;
        RTI:      state <= TMS ? SEL_DR   : RTI;
        SEL_DR:   state <= TMS ? SEL_IR   : CAP_DR;
        CAP_DR:   state <= TMS ? EXIT1_DR : SHIFT_DR;
        SHIFT_DR: state <= TMS ? EXIT1_DR : SHIFT_DR;
        EXIT1_DR: state <= TMS ? UPD_DR   : PAUSE_DR;
        PAUSE_DR: state <= TMS ? EXIT2_DR : PAUSE_DR;
        EXIT2_DR: state <= TMS ? UPD_DR   : SHIFT_DR;
        UPD_DR:   state <= TMS ? SEL_DR   : RTI;
        SEL_IR:   state <= TMS ? TLR      : CAP_IR;
        CAP_IR:   state <= TMS ? EXIT1_IR : SHIFT_IR;
        SHIFT_IR: state <= TMS ? EXIT1_IR : SHIFT_IR;
        EXIT1_IR: state <= TMS ? UPD_IR   : PAUSE_IR;
        PAUSE_IR: state <= TMS ? EXIT2_IR : PAUSE_IR;
        EXIT2_IR: state <= TMS ? UPD_IR   : SHIFT_IR;
        UPD_IR:   state <= TMS ? SEL_DR   : RTI;
      endcase
    end
  end

  // Test-Logic-Reset keeps re-loading the reset instruction, so a TMS-driven reset matches Reset_n.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      ir    <= IR_RESET;
      ir_sr <= 2'b01;
    end else begin
      case (state)
        TLR:      ir    <= IR_RESET;
        CAP_IR:   ir_sr <= 2'b01;
        SHIFT_IR: ir_sr <= {TDI, ir_sr[1]};
        UPD_IR:   ir    <= ir_sr;
        default:  ;
      endcase
    end
  end

  // EXTEST (00) and SAMPLE_PRELOAD (01) both route through the boundary chain.
  assign bsr_sel = ~ir[1];

`ifdef TAP_IDCODE_EN
  logic [31:0] id_reg;

  assign id_sel = (ir == 2'b10);
  assign id_lsb = id_reg[0];

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      id_reg <= IDCODE_VALUE;
    end else if (id_sel && state == CAP_DR) begin
      id_reg <= IDCODE_VALUE;
    end else if (id_sel && state == SHIFT_DR) begin
      id_reg <= {TDI, id_reg[31:1]};
    end
  end
`else
  // IR 10 falls back to bypass; the identifier's fixed LSB is the only trace of it left.
  assign id_sel = 1'b0;
  assign id_lsb = IDCODE_VALUE[0];
`endif

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      bypass_reg <= 1'b0;
    end else if (!bsr_sel && !id_sel) begin
      if (state == CAP_DR) begin
        bypass_reg <= 1'b0;
      end else if (state == SHIFT_DR) begin
        bypass_reg <= TDI;
      end
    end
  end

  always_comb begin
    TDO = 1'b0;
    if (state == SHIFT_IR) begin
      TDO = ir_sr[0];
    end else if (state == SHIFT_DR) begin
      if (bsr_sel)     TDO = BSR_TDO;
      else if (id_sel) TDO = id_lsb;
      else             TDO = bypass_reg;
    end
  end

  assign TDO_en         = (state == SHIFT_IR) || (state == SHIFT_DR);
  assign BSR_ClockEn    = bsr_sel && ((state == CAP_DR) || (state == SHIFT_DR));
  assign Shift_or_Load  = bsr_sel && (state == SHIFT_DR);
  assign Update         = bsr_sel && (state == UPD_DR);
  assign Test_or_Normal = (ir == IR_EXTEST) && (state != TLR);

endmodule
